// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, word type and address helpers (REGFILE_ZERO_REG_EN selects a hardwired zero register)
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    typedef logic [DATA_W_DEF-1:0] word_t;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    function automatic logic addr_in_range(input logic [31:0] addr, input int num_regs);
        return addr < 32'(num_regs);
    endfunction

    // Address 0 is excluded from writes, reservations and reads when hardwired to zero.
    function automatic logic addr_usable(input logic [31:0] addr, input int num_regs);
        return addr_in_range(addr, num_regs) && !(ZERO_REG_EN && addr == 32'd0);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one registered read port with write-first and reserve bypass
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    logic valid;
    logic wr_hit;
    logic rsv_hit;

    // wr_en/rsv_en arrive already qualified, so a hit implies a usable address.
    assign valid   = addr_usable(32'(addr), NUM_REGS);
    assign wr_hit  = wr_en && (w_addr == addr);
    assign rsv_hit = rsv_en && (rsv_addr == addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            busy <= 1'b0;
        end else if (en) begin
            if (!valid) begin
                data <= '0;
                busy <= 1'b0;
            end else begin
                data <= wr_hit ? w_data : mem_data;
                // A same-cycle reservation follows the completing write.
                busy <= rsv_hit ? 1'b1 : (wr_hit ? 1'b0 : mem_busy);
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// rtl/regfile_2r1w_sb.sv - 2-read/1-write register file with busy scoreboard (REGFILE_ZERO_REG_EN hardwires register 0)
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              r1_en,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic [DATA_W-1:0] r1_data,
    output logic              r1_busy,
    input  logic              r2_en,
    input  logic [ADDR_W-1:0] r2_addr,
    output logic [DATA_W-1:0] r2_data,
    output logic              r2_busy
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec;
    logic                wr_en;
    logic                rsv_en;
    logic [DATA_W-1:0]   rd1_mem;
    logic [DATA_W-1:0]   rd2_mem;
    logic                rd1_busy;
    logic                rd2_busy;

    assign wr_en  = ld && addr_usable(32'(w_addr), NUM_REGS);
    assign rsv_en = rsv && addr_usable(32'(rsv_addr), NUM_REGS);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy_vec <= '0;
        end else begin
            if (wr_en) begin
                regs[w_addr]     <= w_data;
                busy_vec[w_addr] <= 1'b0;
            end
            // Placed after the write so a same-address reservation wins.
            if (rsv_en) begin
                busy_vec[rsv_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd1_mem  = '0;
        rd1_busy = 1'b0;
        rd2_mem  = '0;
        rd2_busy = 1'b0;
        if (addr_in_range(32'(r1_addr), NUM_REGS)) begin
            rd1_mem  = regs[r1_addr];
            rd1_busy = busy_vec[r1_addr];
        end
        if (addr_in_range(32'(r2_addr), NUM_REGS)) begin
            rd2_mem  = regs[r2_addr];
            rd2_busy = busy_vec[r2_addr];
        end
    end

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd1 (
        .clk      (clk),
        .rst      (rst),
        .en       (r1_en),
        .addr     (r1_addr),
        .mem_data (rd1_mem),
        .mem_busy (rd1_busy),
        .wr_en    (wr_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .data     (r1_data),
        .busy     (r1_busy)
    );

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd2 (
        .clk      (clk),
        .rst      (rst),
        .en       (r2_en),
        .addr     (r2_addr),
        .mem_data (rd2_mem),
        .mem_busy (rd2_busy),
        .wr_en    (wr_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .data     (r2_data),
        .busy     (r2_busy)
    );

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb/tb_regfile_2r1w_sb.sv - directed and randomized bench for regfile_2r1w_sb (honours REGFILE_ZERO_REG_EN)
module tb_regfile_2r1w_sb;

    localparam int NREG = 16;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ld;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        rsv;
    logic [3:0]  rsv_addr;
    logic        r1_en;
    logic [3:0]  r1_addr;
    logic [31:0] r1_data;
    logic        r1_busy;
    logic        r2_en;
    logic [3:0]  r2_addr;
    logic [31:0] r2_data;
    logic        r2_busy;

    int checks   = 0;
    int failures = 0;

    // Reference state: architectural register contents, busy flags and held read outputs.
    logic [31:0] m_regs [NREG];
    logic        m_busy [NREG];
    logic [31:0] e1_data, e2_data;
    logic        e1_busy, e2_busy;

    always #5 clk = ~clk;

    regfile_2r1w_sb dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .r1_en    (r1_en),
        .r1_addr  (r1_addr),
        .r1_data  (r1_data),
        .r1_busy  (r1_busy),
        .r2_en    (r2_en),
        .r2_addr  (r2_addr),
        .r2_data  (r2_data),
        .r2_busy  (r2_busy)
    );

    function automatic bit usable(input logic [3:0] a);
        return (int'(a) < NREG) && !(ZERO && a == 4'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":r1_data"}, r1_data, e1_data);
        chk({tag, ":r1_busy"}, {31'd0, r1_busy}, {31'd0, e1_busy});
        chk({tag, ":r2_data"}, r2_data, e2_data);
        chk({tag, ":r2_busy"}, {31'd0, r2_busy}, {31'd0, e2_busy});
    endtask

    // Apply one cycle; reads observe the architectural state after this cycle's write and reservation.
    task automatic step(input string tag, input logic l, input logic [3:0] wa, input logic [31:0] wd,
                        input logic rs, input logic [3:0] ra,
                        input logic en1, input logic [3:0] a1, input logic en2, input logic [3:0] a2);
        rst = 1'b0; ld = l; w_addr = wa; w_data = wd; rsv = rs; rsv_addr = ra;
        r1_en = en1; r1_addr = a1; r2_en = en2; r2_addr = a2;
        @(posedge clk);
        if (l && usable(wa)) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (rs && usable(ra)) m_busy[ra] = 1'b1;
        if (en1) begin
            e1_data = usable(a1) ? m_regs[a1] : 32'd0;
            e1_busy = usable(a1) ? m_busy[a1] : 1'b0;
        end
        if (en2) begin
            e2_data = usable(a2) ? m_regs[a2] : 32'd0;
            e2_busy = usable(a2) ? m_busy[a2] : 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; ld = 1'b1; w_addr = 4'd2; w_data = 32'hCAFEF00D;
        rsv = 1'b1; rsv_addr = 4'd2; r1_en = 1'b1; r1_addr = 4'd2; r2_en = 1'b1; r2_addr = 4'd4;
        @(posedge clk);
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
        e1_data = 32'd0; e2_data = 32'd0; e1_busy = 1'b0; e2_busy = 1'b0;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; w_addr = '0; w_data = '0; rsv = 1'b0; rsv_addr = '0;
        r1_en = 1'b0; r1_addr = '0; r2_en = 1'b0; r2_addr = '0;
        @(posedge clk);
        #1;
        do_reset("reset");

        for (int k = 0; k < 16; k++)
            step("fill", 1'b1, 4'(k), 32'hFFFFFF00 + 32'(k), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        for (int k = 0; k < 16; k++)
            step("readback", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'(k), 1'b1, 4'(15 - k));
        chk("readback_last_r1", r1_data, ZERO ? 32'hFFFFFF0F : 32'hFFFFFF0F);
        chk("readback_last_r2", r2_data, ZERO ? 32'd0 : 32'hFFFFFF00);

        step("bypass", 1'b1, 4'd5, 32'hA5A5A5A5, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 4'd0);
        chk("bypass_const", r1_data, 32'hA5A5A5A5);

        step("rsv3", 1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
        step("rsv3_read", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 4'd3);
        chk("rsv3_busy_const", {30'd0, r1_busy, r2_busy}, 32'd3);
        step("wr3", 1'b1, 4'd3, 32'h1234, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        step("wr3_read", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 4'd3);
        chk("wr3_data_const", r1_data, 32'h1234);

        step("rsv_ld7", 1'b1, 4'd7, 32'hDEAD, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0);
        step("rsv_ld7_read", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0);
        chk("rsv_ld7_const", {r1_busy, r1_data[30:0]}, {1'b1, 31'hDEAD});
        step("rsv_ld_bypass", 1'b1, 4'd8, 32'h8888, 1'b1, 4'd8, 1'b1, 4'd8, 1'b1, 4'd8);

        step("hold_pre", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 4'd0);
        step("hold", 1'b1, 4'd9, 32'h99990000, 1'b0, 4'd0, 1'b0, 4'd9, 1'b0, 4'd0);
        do_reset("mid_reset");
        step("post_reset", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 4'd7);
        chk("post_reset_const", r1_data | r2_data, 32'd0);

        step("zero_wr", 1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        step("zero_read", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0);
        chk("zero_const", r1_data, ZERO ? 32'd0 : 32'hFFFFFFFF);
        step("zero_bypass", 1'b1, 4'd0, 32'h0BAD0BAD, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0);

        for (int n = 0; n < 400; n++) begin
            step("random", 1'($urandom), 4'($urandom), 32'($urandom), 1'($urandom_range(0, 3) == 0),
                 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
            if (n == 200) do_reset("random_reset");
        end

        ld = 1'b0; rsv = 1'b0; r1_en = 1'b0; r2_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
Parametrised successor to the 16x32 decoder/register/dual-mux register file. It packages 1 write port and 2 read ports in a single block with synchronous reset, registered reads with write-first bypass, and a per-register busy scoreboard for pipeline hazard detection. It sits between the decode stage (reads, reservations) and writeback (writes) of the datapath.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 4, register address width
NUM_REGS, 1<<ADDR_W, number of registers; must be <= 2**ADDR_W; addresses >= NUM_REGS are out of range

Ports:
clk  in  1  single clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
ld  in  1  write enable
w_addr  in  ADDR_W  write address
w_data  in  DATA_W  write data
rsv  in  1  reserve enable: mark a register busy (pending write)
rsv_addr  in  ADDR_W  register to reserve
r1_en  in  1  read port 1 enable
r1_addr  in  ADDR_W  read port 1 address
r1_data  out  DATA_W  read port 1 data, registered
r1_busy  out  1  busy bit of r1_addr at sample time, registered
r2_en, r2_addr, r2_data, r2_busy: same as port 1, for port 2

Behaviour:
- Reset (rst=1 at posedge): all registers=0, all busy bits=0, r1_data=r2_data=0, r1_busy=r2_busy=0. rst overrides ld, rsv and reads in the same cycle.
- Write: at posedge, ld=1 and w_addr in range -> reg[w_addr]<=w_data and busy[w_addr]<=0. If w_addr is out of range, the write is silently dropped.
- Read: rN_en=1 at posedge -> rN_data<=reg[rN_addr] and rN_busy<=busy[rN_addr]. Latency is 1 cycle. rN_en=0 -> rN_data and rN_busy hold their values.
- Out-of-range read returns data 0 and busy 0.
- Bypass (write-first): ld=1 and rN_en=1 with rN_addr==w_addr in the same cycle -> rN_data<=w_data and rN_busy<=0. This applies to both ports independently.
- Reserve: rsv=1 and rsv_addr in range -> busy[rsv_addr]<=1.
- Reserve-bypass: rsv=1 and rN_en=1 with rN_addr==rsv_addr in the same cycle -> rN_busy<=1. When a write also targets the same address, the reservation takes precedence: rN_busy<=1, rN_data<=w_data.
- Simultaneous rsv and ld on the same address: data is written and busy ends at 1, because the new reservation follows the completing write.
- Both read ports may use the same address in the same cycle and return identical values.
- No internal FSM beyond the register array and busy vector. Busy bits persist until written or reset.

Optional Feature:
Macro: REGFILE_ZERO_REG_EN
- Defined: register 0 is hardwired to zero. Writes to address 0 are dropped and reservations of address 0 are ignored. Reads of address 0 return 0 with busy 0, including under bypass.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W localparams and a typedef for the register data word.
- Sub-module regfile_rd_port: one read port holding the enable/hold register, write-first bypass, reserve-bypass and out-of-range masking. It is instantiated twice.
- The top level owns the storage array, the busy vector and the write/reserve decode.

Test Plan:
1. Reset, then write reg k = 32'hFFFFFF00+k for k=0..15 (one per cycle), then read r1=k, r2=15-k -> data matches 1 cycle after the read, busy=0 throughout.
2. Same-cycle ld=1, w_addr=5, w_data=32'hA5A5A5A5 with r1_addr=5, r1_en=1 -> next cycle r1_data=32'hA5A5A5A5 and r1_busy=0.
3. rsv=1, rsv_addr=3, then read 3 on both ports -> r1_busy=r2_busy=1. Then ld to 3 with 32'h1234 -> a read in the following cycle gives busy=0, data=32'h1234.
4. rsv and ld both to addr 7 in the same cycle with data 32'hDEAD -> a subsequent read of 7 gives 32'hDEAD, busy=1.
5. Hold r1_en=0 while writing to r1_addr -> r1_data unchanged. Assert rst mid-sequence -> all outputs 0 next cycle, and reading any register returns 0, busy 0.
6. With REGFILE_ZERO_REG_EN: ld to addr 0 with 32'hFFFFFFFF plus rsv 0 -> reads of 0 return 0, busy 0. Without the macro, the same sequence returns 32'hFFFFFFFF, busy 1.
